// File: rtl/pc_ras_unit.sv
// Program counter with branch/jump/call/return/exception redirect
// and a circular return-address stack.
module pc_ras_unit #(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = 'h0,
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = 'h80,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         zeroflag,
    input  logic                         branchFlag,
    input  logic                         branchNe,
    input  logic [WIDTH-1:0]             branchOffset,
    input  logic                         jmpFlag,
    input  logic [WIDTH-1:0]             jmpAddress,
    input  logic                         callFlag,
    input  logic                         retFlag,
    input  logic                         excFlag,
    output logic [WIDTH-1:0]             out,
    output logic [$clog2(RAS_DEPTH):0]   rasCount,
    output logic                         rasOverflow,
    output logic                         rasUnderflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] ALIGN = {{(WIDTH-2){1'b1}}, 2'b00};
    localparam logic [CW-1:0]    FULL  = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rd_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push_en;
    logic             taken;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] br_pc;
    logic [WIDTH-1:0] top;

    assign seq_pc = pc_q + WIDTH'(4);
    assign br_pc  = seq_pc + (branchOffset << 2);
    assign taken  = branchFlag & (zeroflag ^ branchNe);
    assign rd_idx = wp_q - PW'(1);
    assign top    = ras_q[rd_idx];

    // Next-PC selection by fixed priority and stack pointer/count update.
    always_comb begin
        pc_d    = pc_q;
        wp_d    = wp_q;
        cnt_d   = cnt_q;
        push_en = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (excFlag) begin
            pc_d = EXC_VECTOR & ALIGN;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (retFlag) begin
            if (cnt_q != '0) begin
                pc_d  = top & ALIGN;
                wp_d  = rd_idx;
                cnt_d = cnt_q - CW'(1);
            end else begin
                pc_d  = jmpAddress & ALIGN;
                unf_d = 1'b1;
            end
        end else if (callFlag) begin
            pc_d    = jmpAddress & ALIGN;
            push_en = 1'b1;
            wp_d    = wp_q + PW'(1);
            if (cnt_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (jmpFlag) begin
            pc_d = jmpAddress & ALIGN;
        end else if (taken) begin
            pc_d = br_pc & ALIGN;
        end else begin
            pc_d = seq_pc & ALIGN;
        end
    end

    // PC, stack pointer, count and event pulses; cleared by async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            wp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage; contents become unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (push_en && !rst) begin
            ras_q[wp_q] <= seq_pc;
        end
    end

    assign out          = pc_q;
    assign rasCount     = cnt_q;
    assign rasOverflow  = ovf_q;
    assign rasUnderflow = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed self-checking bench for pc_ras_unit.
// Linear step sequence with immediate assertions.
module tb_pc_ras_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        zeroflag;
    logic        branchFlag;
    logic        branchNe;
    logic [31:0] branchOffset;
    logic        jmpFlag;
    logic [31:0] jmpAddress;
    logic        callFlag;
    logic        retFlag;
    logic        excFlag;
    logic [31:0] out;
    logic [2:0]  rasCount;
    logic        rasOverflow;
    logic        rasUnderflow;

    int tests;
    int fails;

    pc_ras_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .zeroflag     (zeroflag),
        .branchFlag   (branchFlag),
        .branchNe     (branchNe),
        .branchOffset (branchOffset),
        .jmpFlag      (jmpFlag),
        .jmpAddress   (jmpAddress),
        .callFlag     (callFlag),
        .retFlag      (retFlag),
        .excFlag      (excFlag),
        .out          (out),
        .rasCount     (rasCount),
        .rasOverflow  (rasOverflow),
        .rasUnderflow (rasUnderflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; zeroflag = 0; branchFlag = 0; branchNe = 0;
        branchOffset = 0; jmpFlag = 0; jmpAddress = 0;
        callFlag = 0; retFlag = 0; excFlag = 0;
    endtask

    task automatic do_jmp(input logic [31:0] a);
        idle(); jmpFlag = 1; jmpAddress = a; tick(); idle();
    endtask

    task automatic do_call(input logic [31:0] a);
        idle(); callFlag = 1; jmpAddress = a; tick(); idle();
    endtask

    task automatic do_ret(input logic [31:0] a);
        idle(); retFlag = 1; jmpAddress = a; tick(); idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle();
        rst = 1;
        #1;
        chk("rst_async_out", out, 32'h0);
        chk("rst_async_cnt", {29'b0, rasCount}, 32'h0);
        tick();
        tick();
        chk("rst_hold_out", out, 32'h0);
        chk("rst_flags", {30'b0, rasOverflow, rasUnderflow}, 32'h0);
        rst = 0;
        tick(); chk("seq1", out, 32'h4);
        tick(); chk("seq2", out, 32'h8);
        tick(); chk("seq3", out, 32'hC);
        chk("seq_cnt", {29'b0, rasCount}, 32'h0);
        tick(); chk("seq4", out, 32'h10);

        branchFlag = 1; zeroflag = 1; branchOffset = -32'sd3;
        tick(); chk("beq_taken", out, 32'h8);
        do_jmp(32'h10); chk("jmp10", out, 32'h10);
        branchFlag = 1; zeroflag = 0; branchOffset = -32'sd3;
        tick(); chk("beq_not", out, 32'h14);
        do_jmp(32'h10);
        branchFlag = 1; branchNe = 1; zeroflag = 0;
        branchOffset = -32'sd3;
        tick(); chk("bne_taken", out, 32'h8);
        branchFlag = 1; branchNe = 1; zeroflag = 1;
        branchOffset = -32'sd3;
        tick(); chk("bne_not", out, 32'hC);
        idle();

        do_jmp(32'h20);
        do_call(32'h340C);
        chk("call_out", out, 32'h340C);
        chk("call_cnt", {29'b0, rasCount}, 32'h1);
        do_ret(32'h0);
        chk("ret_out", out, 32'h24);
        chk("ret_cnt", {29'b0, rasCount}, 32'h0);

        do_jmp(32'h1003);
        chk("jmp_align", out, 32'h1000);
        do_call(32'h100);
        do_call(32'h200);
        do_call(32'h300);
        do_call(32'h400);
        chk("call4_cnt", {29'b0, rasCount}, 32'h4);
        chk("call4_ovf", {31'b0, rasOverflow}, 32'h0);
        do_call(32'h500);
        chk("call5_out", out, 32'h500);
        chk("call5_cnt", {29'b0, rasCount}, 32'h4);
        chk("call5_ovf", {31'b0, rasOverflow}, 32'h1);
        do_ret(32'h0);
        chk("pop1", out, 32'h404);
        chk("pop1_ovf", {31'b0, rasOverflow}, 32'h0);
        chk("pop1_cnt", {29'b0, rasCount}, 32'h3);
        do_ret(32'h0); chk("pop2", out, 32'h304);
        do_ret(32'h0); chk("pop3", out, 32'h204);
        do_ret(32'h0); chk("pop4", out, 32'h104);
        chk("pop4_cnt", {29'b0, rasCount}, 32'h0);
        chk("pop4_unf", {31'b0, rasUnderflow}, 32'h0);
        do_ret(32'h7778);
        chk("unf_out", out, 32'h7778);
        chk("unf_flag", {31'b0, rasUnderflow}, 32'h1);
        chk("unf_cnt", {29'b0, rasCount}, 32'h0);
        tick();
        chk("unf_clear", {31'b0, rasUnderflow}, 32'h0);
        chk("after_unf", out, 32'h777C);

        do_call(32'h600);
        retFlag = 1; callFlag = 1; jmpAddress = 32'h900;
        tick(); idle();
        chk("retcall_out", out, 32'h7780);
        chk("retcall_cnt", {29'b0, rasCount}, 32'h0);

        do_call(32'h2000);
        stall = 1; callFlag = 1; jmpAddress = 32'h5000;
        tick(); chk("stall1", out, 32'h2000);
        tick(); chk("stall2", out, 32'h2000);
        tick(); chk("stall3", out, 32'h2000);
        chk("stall_cnt", {29'b0, rasCount}, 32'h1);
        chk("stall_flags", {30'b0, rasOverflow, rasUnderflow}, 32'h0);
        idle();
        stall = 1; excFlag = 1; retFlag = 1;
        tick(); idle();
        chk("exc_out", out, 32'h80);
        chk("exc_cnt", {29'b0, rasCount}, 32'h1);
        tick(); chk("exc_seq", out, 32'h84);
        do_ret(32'h0);
        chk("exc_ret", out, 32'h7784);

        do_call(32'h3000);
        do_call(32'h3100);
        chk("pre_rst_cnt", {29'b0, rasCount}, 32'h2);
        #3 rst = 1;
        #1;
        chk("arst_out", out, 32'h0);
        chk("arst_cnt", {29'b0, rasCount}, 32'h0);
        #1 rst = 0;
        do_ret(32'h4444);
        chk("arst_ret", out, 32'h4444);
        chk("arst_unf", {31'b0, rasUnderflow}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
